fir_csr_ctrl: RTL and testbench

Parametrised register/control slave for the FIR filter core, the successor to the fixed 8-tap CSR. It exposes NTAPS programmable coefficients, a control/status register, and an output-sample FIFO on a single-cycle Avalon-MM-style slave port. It sits between the system interconnect and the FIR datapath: it drives the coefficient bus and start/flush strobes, and captures filter results for software readout.

---
 rtl/fir_csr_ctrl.sv | 154 +++++++++++++++
 tb/tb_fir_csr_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fir_csr_ctrl.sv
// CSR slave for the parametrised FIR core: coefficient bank, CTRL/STATUS, output-sample FIFO.
// Optional feature: define FIR_CSR_IRQ_EN to enable the level interrupt and the IRQ_EN bit.
module fir_csr_ctrl #(
  parameter int NTAPS      = 8,
  parameter int COEF_W     = 8,
  parameter int DOUT_W     = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      chipselect,
  input  logic                      write,
  input  logic                      read,
  input  logic [5:0]                address,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      irq,
  output logic [NTAPS*COEF_W-1:0]   coef_bus,
  output logic                      start,
  output logic                      flush,
  input  logic                      core_idle,
  input  logic                      dout_valid,
  input  logic signed [DOUT_W-1:0]  dout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [5:0] A_CTRL = 6'h20;
  localparam logic [5:0] A_STAT = 6'h21;
  localparam logic [5:0] A_DOUT = 6'h22;

  logic [NTAPS*COEF_W-1:0] coef_q;
  logic [31:0]             readdata_q, rdata_d;
  logic                    start_q, flush_q, ovf_q, ovf_d, werr_q, werr_d, irq_en;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]             count_q, count_d;
  logic [DOUT_W-1:0]       mem_q [FIFO_DEPTH];
  logic signed [DOUT_W-1:0] head_s;

  logic wr_en, rd_en, ctrl_wr, stat_wr, coef_sel, start_bit;
  logic start_req, flush_req, werr_set, empty, full, pop, push;
  logic unused_wdata;

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign ctrl_wr   = wr_en & (address == A_CTRL);
  assign stat_wr   = wr_en & (address == A_STAT);
  assign coef_sel  = address < 6'(NTAPS);
  assign start_bit = ctrl_wr & writedata[0] & ~writedata[2];
  assign flush_req = ctrl_wr & writedata[2];
  assign start_req = start_bit & core_idle;
  assign werr_set  = ~core_idle & ((wr_en & coef_sel) | start_bit);

  assign empty  = (count_q == '0);
  assign full   = (count_q == (PW+1)'(FIFO_DEPTH));
  assign pop    = rd_en & (address == A_DOUT) & ~empty;
  // A pop frees the head slot in the same edge, so a full FIFO can still accept.
  assign push   = dout_valid & (~full | pop) & ~flush_req;
  assign head_s = mem_q[rd_ptr_q];

  assign unused_wdata = ^writedata;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end

    ovf_d = ovf_q;
    if (stat_wr && writedata[3]) ovf_d = 1'b0;
    if (dout_valid && full && !pop && !flush_req) ovf_d = 1'b1;

    werr_d = werr_q;
    if (stat_wr && writedata[4]) werr_d = 1'b0;
    if (werr_set) werr_d = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    if (coef_sel) begin
      for (int i = 0; i < NTAPS; i++)
        if (address == 6'(i)) rdata_d[COEF_W-1:0] = coef_q[i*COEF_W +: COEF_W];
    end
    case (address)
      A_CTRL: rdata_d[1] = irq_en;
      A_STAT: begin
        rdata_d[0]    = core_idle;
        rdata_d[1]    = empty;
        rdata_d[2]    = full;
        rdata_d[3]    = ovf_q;
        rdata_d[4]    = werr_q;
        rdata_d[14:8] = 7'(count_q);
      end
      A_DOUT: if (!empty) rdata_d = 32'(head_s);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_q     <= '0;
      readdata_q <= '0;
      start_q    <= 1'b0;
      flush_q    <= 1'b0;
      ovf_q      <= 1'b0;
      werr_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      for (int i = 0; i < NTAPS; i++)
        if (wr_en && core_idle && address == 6'(i))
          coef_q[i*COEF_W +: COEF_W] <= writedata[COEF_W-1:0];
      if (rd_en) readdata_q <= rdata_d;
      start_q  <= start_req;
      flush_q  <= flush_req;
      ovf_q    <= ovf_d;
      werr_q   <= werr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dout;
  end

`ifdef FIR_CSR_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       irq_en <= 1'b0;
    else if (ctrl_wr) irq_en <= writedata[1];
  end
  assign irq = irq_en & (~empty | ovf_q);
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  assign readdata = readdata_q;
  assign coef_bus = coef_q;
  assign start    = start_q;
  assign flush    = flush_q;

endmodule

// File: tb/tb_fir_csr_ctrl.sv
// Directed bench for fir_csr_ctrl with default parameters (NTAPS=8, COEF_W=8, DOUT_W=18, FIFO_DEPTH=4).
module tb_fir_csr_ctrl;

  localparam int NTAPS = 8, COEF_W = 8, DOUT_W = 18, FIFO_DEPTH = 4;
`ifdef FIR_CSR_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk, rst_n, chipselect, write, read, irq, start, flush, core_idle, dout_valid;
  logic [5:0]  address;
  logic [31:0] writedata, readdata, r;
  logic [NTAPS*COEF_W-1:0] coef_bus;
  logic signed [DOUT_W-1:0] dout;
  int n_chk = 0;
  int n_pass = 0;

  fir_csr_ctrl #(.NTAPS(NTAPS), .COEF_W(COEF_W), .DOUT_W(DOUT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .irq(irq),
    .coef_bus(coef_bus), .start(start), .flush(flush), .core_idle(core_idle),
    .dout_valid(dout_valid), .dout(dout));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic push(input logic [DOUT_W-1:0] v);
    @(negedge clk);
    dout_valid = 1'b1; dout = v;
    @(negedge clk);
    dout_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0; address = '0;
    writedata = '0; core_idle = 1'b1; dout_valid = 1'b0; dout = '0;
    repeat (2) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_start", 32'(start), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_coef_lo", coef_bus[31:0], 32'h0);
    check("rst_coef_hi", coef_bus[63:32], 32'h0);
    rst_n = 1'b1;

    for (int a = 0; a <= 'h22; a++) begin
      rd(6'(a), r);
      check($sformatf("rst_rd_%02h", a), r, (a == 'h21) ? 32'h3 : 32'h0);
    end

    // coefficient write, out-of-range tap, write while busy
    wr(6'h03, 32'hFFFF_FFA5);
    check("coef3_bus", 32'(coef_bus[31:24]), 32'hA5);
    rd_chk("coef3_rd", 6'h03, 32'hA5);
    wr(6'h08, 32'hFF);
    rd_chk("coef8_rd", 6'h08, 32'h0);
    core_idle = 1'b0;
    wr(6'h03, 32'h11);
    check("coef3_busy", 32'(coef_bus[31:24]), 32'hA5);
    rd_chk("stat_werr", 6'h21, 32'h12);
    wr(6'h21, 32'h10);
    rd_chk("stat_werr_clr", 6'h21, 32'h02);
    core_idle = 1'b1;

    // sign extension and empty read
    push(18'h3FFFF);
    push(18'h00005);
    rd_chk("stat_lvl2", 6'h21, 32'h201);
    rd_chk("dout_neg", 6'h22, 32'hFFFF_FFFF);
    rd_chk("dout_pos", 6'h22, 32'h5);
    rd_chk("dout_empty", 6'h22, 32'h0);
    rd_chk("stat_empty", 6'h21, 32'h3);

    // overflow and interrupt
    wr(6'h20, 32'h2);
    rd_chk("ctrl_irqen", 6'h20, IRQ_ON ? 32'h2 : 32'h0);
    check("irq_idle", 32'(irq), 32'h0);
    for (int v = 1; v <= 5; v++) push(18'(v));
    rd_chk("stat_ovf", 6'h21, 32'h40D);
    check("irq_full", 32'(irq), 32'(IRQ_ON));
    for (int v = 1; v <= 4; v++) rd_chk($sformatf("ovf_pop%0d", v), 6'h22, 32'(v));
    check("irq_ovf_only", 32'(irq), 32'(IRQ_ON));
    rd_chk("stat_ovf_empty", 6'h21, 32'hB);
    wr(6'h21, 32'h08);
    check("irq_cleared", 32'(irq), 32'h0);
    rd_chk("stat_ovf_clr", 6'h21, 32'h3);

    // full FIFO: push coincident with pop
    for (int v = 'h10; v <= 'h13; v++) push(18'(v));
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 6'h22; dout_valid = 1'b1; dout = 18'h14;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; dout_valid = 1'b0;
    check("full_pp_rd", readdata, 32'h10);
    rd_chk("full_pp_stat", 6'h21, 32'h405);
    for (int v = 'h11; v <= 'h14; v++) rd_chk($sformatf("full_pp_pop%0h", v), 6'h22, 32'(v));

    // start and flush pulses
    wr(6'h20, 32'h1);
    check("start_hi", 32'(start), 32'h1);
    check("start_noflush", 32'(flush), 32'h0);
    @(negedge clk);
    check("start_lo", 32'(start), 32'h0);
    push(18'h7);
    wr(6'h20, 32'h5);
    check("flush_hi", 32'(flush), 32'h1);
    check("flush_nostart", 32'(start), 32'h0);
    @(negedge clk);
    check("flush_lo", 32'(flush), 32'h0);
    rd_chk("flush_stat", 6'h21, 32'h3);

    // flush coincident with dout_valid discards the sample
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 6'h20; writedata = 32'h4;
    dout_valid = 1'b1; dout = 18'h9;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; dout_valid = 1'b0;
    rd_chk("flush_push_stat", 6'h21, 32'h3);

    // empty FIFO: push coincident with DOUT read
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 6'h22; dout_valid = 1'b1; dout = 18'h20000;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; dout_valid = 1'b0;
    check("empty_pp_rd", readdata, 32'h0);
    rd_chk("empty_pp_stat", 6'h21, 32'h101);
    rd_chk("empty_pp_pop", 6'h22, 32'hFFFE_0000);

    // start while busy is dropped
    core_idle = 1'b0;
    wr(6'h20, 32'h1);
    check("busy_nostart", 32'(start), 32'h0);
    rd_chk("busy_werr", 6'h21, 32'h12);
    core_idle = 1'b1;
    wr(6'h21, 32'h10);

    // simultaneous read and write returns the pre-write value
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 6'h00; writedata = 32'h3C;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    check("rw_pre", readdata, 32'h0);
    check("rw_coef0", 32'(coef_bus[7:0]), 32'h3C);

    // asynchronous reset kills an in-flight start pulse
    wr(6'h20, 32'h1);
    check("rst_mid_start_pre", 32'(start), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_start", 32'(start), 32'h0);
    check("rst_mid_coef", coef_bus[31:0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("rst_mid_stat", 6'h21, 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
